gated_edge_counter: RTL and testbench

//  Receiving end of the gate-enable interface driven by enable_toggle.

---
 rtl/gated_edge_counter.sv | 99 +++++++++
 tb/tb_gated_edge_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/gated_edge_counter.sv
// gated_edge_counter: counts synchronized rising edges of sig_in while the enable gate is open,
// then latches the count and strobes count_valid when the gate closes.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   enable       gate window, synchronous to clk
//   sig_in       measured signal, asynchronous to clk
//   count_out    edge count of the last completed gate (saturating)
//   count_valid  one-cycle strobe when count_out/overflow update
//   overflow     last completed gate saturated the counter
//   busy         gate window in progress
module gated_edge_counter #(
   parameter int CNT_WIDTH   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] count_out,
   output logic                 count_valid,
   output logic                 overflow,
   output logic                 busy
);
   typedef enum logic {IDLE, COUNT} state_t;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   en_dly_q, en_dly_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0]   count_out_q, count_out_d;
   logic                   overflow_q, overflow_d;
   logic                   valid_q, valid_d;
   logic                   sig_edge, rise, fall;
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_d      = sync_q[SYNC_STAGES-1];
      en_dly_d    = enable;
      sig_edge    = sync_q[SYNC_STAGES-1] & ~hist_q;
      rise        = enable & ~en_dly_q;
      fall        = ~enable & en_dly_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      count_out_d = count_out_q;
      overflow_d  = overflow_q;
      valid_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = COUNT;
               cnt_d   = CNT_WIDTH'(sig_edge);
               ovf_d   = 1'b0;
            end
         end
         default: begin
            // an edge arriving in the closing cycle is deliberately dropped
            if (fall) begin
               state_d     = IDLE;
               count_out_d = cnt_q;
               overflow_d  = ovf_q;
               valid_d     = 1'b1;
            end else if (sig_edge) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
               ovf_d = ovf_q | (cnt_q == CNT_MAX);
            end
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sync_q      <= '0;
         hist_q      <= 1'b0;
         en_dly_q    <= 1'b0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         count_out_q <= '0;
         overflow_q  <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         hist_q      <= hist_d;
         en_dly_q    <= en_dly_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         count_out_q <= count_out_d;
         overflow_q  <= overflow_d;
         valid_q     <= valid_d;
      end
   end
   assign count_out   = count_out_q;
   assign count_valid = valid_q;
   assign overflow    = overflow_q;
   assign busy        = (state_q == COUNT);
endmodule

// File: tb/tb_gated_edge_counter.sv
// tb_gated_edge_counter: scoreboard bench driving a 32-bit and a 4-bit counter with the same
// gate/signal stimulus and checking both against a gate-level reference model.
module tb_gated_edge_counter;
   localparam int S = 2;
   logic        clk = 1'b0, rst = 1'b0, enable = 1'b0, sig_in = 1'b0;
   logic [31:0] co32;
   logic        v32, o32, b32;
   logic [3:0]  co4;
   logic        v4, o4, b4;
   int          errors = 0, checks = 0;
   longint      q32[$], q4[$];
   bit          sh[S+1];
   bit          in_win = 0, e_prev = 0, ev = 0;
   longint      raw = 0;
   longint      held32 = 0, held4 = 0, r32, r4;
   bit          hov32 = 0, hov4 = 0;

   always #5 clk = ~clk;

   gated_edge_counter #(.CNT_WIDTH(32), .SYNC_STAGES(S)) dut32 (
      .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
      .count_out(co32), .count_valid(v32), .overflow(o32), .busy(b32));
   gated_edge_counter #(.CNT_WIDTH(4), .SYNC_STAGES(S)) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
      .count_out(co4), .count_valid(v4), .overflow(o4), .busy(b4));

   function automatic longint sat(longint r, int w);
      longint m = (longint'(1) << w) - 1;
      return (r > m) ? m : r;
   endfunction

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an edge is a 0->1 step in the sig_in samples seen S+1 clocks back;
   // a gate counts edges on every enabled sample after its opening sample, plus the opening one.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_win = 0;
         raw    = 0;
         e_prev = 0;
         for (int k = 0; k <= S; k++) sh[k] = 0;
      end else begin
         ev = sh[S-1] & ~sh[S];
         if (in_win) begin
            if (enable) raw += longint'(ev);
            else begin
               q32.push_back(raw);
               q4.push_back(raw);
               in_win = 0;
            end
         end else if (enable && !e_prev) begin
            in_win = 1;
            raw    = longint'(ev);
         end
         e_prev = enable;
         for (int k = S; k > 0; k--) sh[k] = sh[k-1];
         sh[0] = sig_in;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_count32", co32, 0); chk("rst_valid32", v32, 0);
         chk("rst_ovf32", o32, 0);    chk("rst_busy32", b32, 0);
         held32 = 0; hov32 = 0;
      end else begin
         chk("busy32", b32, longint'(in_win));
         if (v32) begin
            if (q32.size() == 0) chk("spurious_valid32", 1, 0);
            else begin
               r32 = q32.pop_front();
               held32 = sat(r32, 32);
               hov32 = (r32 > held32);
            end
         end
         chk("count32", co32, held32);
         chk("ovf32", o32, longint'(hov32));
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_count4", co4, 0); chk("rst_valid4", v4, 0);
         chk("rst_ovf4", o4, 0);    chk("rst_busy4", b4, 0);
         held4 = 0; hov4 = 0;
      end else begin
         chk("busy4", b4, longint'(in_win));
         if (v4) begin
            if (q4.size() == 0) chk("spurious_valid4", 1, 0);
            else begin
               r4 = q4.pop_front();
               held4 = sat(r4, 4);
               hov4 = (r4 > held4);
            end
         end
         chk("count4", co4, held4);
         chk("ovf4", o4, longint'(hov4));
      end
   end

   task automatic tick(bit e, bit s);
      @(negedge clk);
      #1;
      enable = e;
      sig_in = s;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(0, 0);
   endtask

   task automatic gate(int n, int half);
      for (int i = 0; i < n; i++) tick(1, ((i / half) % 2) == 1);
   endtask

   initial begin
      // reset held while inputs wiggle; sig_in stays high across release
      for (int i = 0; i < 8; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick(0, 1);
      @(negedge clk); #1; rst = 1'b1;
      idle(10);
      gate(1000, 5); idle(3);
      for (int i = 0; i < 500; i++) tick(1, 0);
      idle(3);
      gate(80, 2); tick(0, 0); gate(12, 2); idle(3);
      // reset in the middle of a gate, gate dropped while reset is held
      gate(300, 3);
      @(negedge clk); #1; rst = 1'b0;
      tick(0, 0); tick(0, 0); tick(0, 0);
      @(negedge clk); #1; rst = 1'b1;
      idle(5);
      gate(200, 2); tick(0, 0); gate(80, 2); idle(4);
      // edge on the opening sample, then edge on the closing sample
      tick(0, 1); tick(0, 1); tick(1, 1); tick(1, 0); tick(1, 0);
      tick(1, 1); tick(1, 1); tick(0, 1); idle(5);
      for (int g = 0; g < 40; g++) begin
         int len = $urandom_range(1, 60);
         int gap = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) tick(1, 1'($urandom_range(0, 1)));
         for (int i = 0; i < gap; i++) tick(0, 1'($urandom_range(0, 1)));
      end
      idle(6);
      chk("pending32", q32.size(), 0);
      chk("pending4", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
